am_tx_scheduler: RTL and testbench

- Schedules 40GBASE-R transmit alignment-marker (AM) slots across LANE_N PCS lanes.
- Decides which block slot carries AMs and stalls the upstream block stream for that slot.
- Accumulates per-lane BIP3 parity over the transmitted blocks and supplies BIP3/BIP7 to the per-lane marker insertion datapath.
- Sits between the scrambler output and the lane gearbox, pacing on the gearbox slot strobe.

---
 rtl/am_tx_scheduler.sv | 126 ++++++++++++
 tb/tb_am_tx_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/am_tx_scheduler.sv
// Transmit alignment-marker slot scheduler for multi-lane 40GBASE-R PCS.
// Paces on the gearbox slot strobe, stalls upstream on AM slots and keeps per-lane BIP3.
module am_tx_scheduler #(
  parameter int LANE_N  = 4,
  parameter int BLOCK_W = 66,
  parameter int AM_GAP  = 16383,
  parameter int CNT_W   = 14
) (
  input  logic                        clk,
  input  logic                        nreset,
  input  logic                        en_i,
  input  logic                        slot_v_i,
  input  logic [LANE_N*BLOCK_W-1:0]   lane_data_i,
  output logic                        up_ready_o,
  output logic                        am_v_o,
  output logic [LANE_N*8-1:0]         bip3_o,
  output logic [LANE_N*8-1:0]         bip7_o,
  output logic                        am_sent_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AM   = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(AM_GAP - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LANE_N*8-1:0]   acc_q, acc_d;
  logic                  am_v_q, am_v_d;
  logic                  am_sent_q, am_sent_d;
  logic [LANE_N*8-1:0]   blk_par;

  // BIP bit i covers payload bits i+2, i+10, ...; bits 3 and 4 also fold in the sync header.
  function automatic logic [7:0] bip_parity(input logic [BLOCK_W-1:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) begin
        p[i] = p[i] ^ b[i + 2 + 8 * k];
      end
    end
    p[3] = p[3] ^ b[0];
    p[4] = p[4] ^ b[1];
    return p;
  endfunction

  always_comb begin
    blk_par = '0;
    for (int l = 0; l < LANE_N; l++) begin
      blk_par[l*8 +: 8] = bip_parity(lane_data_i[l*BLOCK_W +: BLOCK_W]);
    end
  end

  // Slot gaps (slot_v_i=0) freeze everything so the AM period counts consumed slots only.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    am_sent_d = (state_q == ST_AM) && slot_v_i;
    if (!en_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_AM;
          cnt_d   = '0;
          acc_d   = '0;
        end
        ST_AM: begin
          if (slot_v_i) begin
            // The marker block itself opens the next BIP interval.
            state_d = ST_DATA;
            cnt_d   = '0;
            acc_d   = blk_par;
          end
        end
        ST_DATA: begin
          if (slot_v_i) begin
            acc_d = acc_q ^ blk_par;
            if (cnt_q == GAP_LAST) begin
              state_d = ST_AM;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          acc_d   = '0;
        end
      endcase
    end
    am_v_d = (state_d == ST_AM);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      am_v_q    <= 1'b0;
      am_sent_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      am_v_q    <= am_v_d;
      am_sent_q <= am_sent_d;
    end
  end

  // Upstream handshake: a block is taken exactly when the gearbox consumes a data slot.
  assign up_ready_o = slot_v_i && (state_q == ST_DATA);
  assign am_v_o     = am_v_q;
  assign bip3_o     = acc_q;
  assign bip7_o     = ~acc_q;
  assign am_sent_o  = am_sent_q;

endmodule

// File: tb/tb_am_tx_scheduler.sv
// Directed bench for am_tx_scheduler: AM_GAP=4 instance for pacing, AM_GAP=2 instance for BIP.
module tb_am_tx_scheduler;

  localparam int LANE_N  = 4;
  localparam int BLOCK_W = 66;
  localparam int DW      = LANE_N * BLOCK_W;

  logic          clk;
  logic          nreset;
  logic          en_i;
  logic          slot_v_i;
  logic [DW-1:0] lane_data_i;

  logic          g4_up_ready, g4_am_v, g4_am_sent;
  logic [31:0]   g4_bip3, g4_bip7;
  logic          g2_up_ready, g2_am_v, g2_am_sent;
  logic [31:0]   g2_bip3, g2_bip7;

  int n_checks;
  int n_errors;

  am_tx_scheduler #(.LANE_N(LANE_N), .BLOCK_W(BLOCK_W), .AM_GAP(4), .CNT_W(14)) dut_g4 (
    .clk         (clk),
    .nreset      (nreset),
    .en_i        (en_i),
    .slot_v_i    (slot_v_i),
    .lane_data_i (lane_data_i),
    .up_ready_o  (g4_up_ready),
    .am_v_o      (g4_am_v),
    .bip3_o      (g4_bip3),
    .bip7_o      (g4_bip7),
    .am_sent_o   (g4_am_sent)
  );

  am_tx_scheduler #(.LANE_N(LANE_N), .BLOCK_W(BLOCK_W), .AM_GAP(2), .CNT_W(14)) dut_g2 (
    .clk         (clk),
    .nreset      (nreset),
    .en_i        (en_i),
    .slot_v_i    (slot_v_i),
    .lane_data_i (lane_data_i),
    .up_ready_o  (g2_up_ready),
    .am_v_o      (g2_am_v),
    .bip3_o      (g2_bip3),
    .bip7_o      (g2_bip7),
    .am_sent_o   (g2_am_sent)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic restart();
    en_i = 1'b0;
    tick();
    en_i = 1'b1;
    tick();
  endtask

  initial begin
    logic [DW-1:0] v;
    int            k;
    logic          exp_am, prev_am_slot;
    int            lane;

    n_checks    = 0;
    n_errors    = 0;
    nreset      = 1'b0;
    en_i        = 1'b0;
    slot_v_i    = 1'b1;
    lane_data_i = '0;
    tick();
    tick();

    // reset state
    settle();
    check("rst_am_v", g4_am_v, 0);
    check("rst_up_ready", g4_up_ready, 0);
    check("rst_bip3", g4_bip3, 0);
    check("rst_bip7", g4_bip7, 32'hFFFF_FFFF);
    check("rst_am_sent", g4_am_sent, 0);

    // constant slot strobe, AM_GAP=4
    nreset = 1'b1;
    en_i   = 1'b1;
    settle();
    check("idle_am_v", g4_am_v, 0);
    check("idle_up_ready", g4_up_ready, 0);
    tick();
    for (int s = 0; s < 11; s++) begin
      settle();
      check("const_am_v", g4_am_v, (s % 5) == 0);
      check("const_up_ready", g4_up_ready, (s % 5) != 0);
      check("const_am_sent", g4_am_sent, (s > 0) && ((s - 1) % 5 == 0));
      tick();
    end

    // toggling slot strobe: period counts consumed slots only
    restart();
    k = 0;
    prev_am_slot = 1'b0;
    for (int c = 0; c < 22; c++) begin
      slot_v_i = (c % 2) == 0;
      exp_am   = (k % 5) == 0;
      settle();
      check("tog_am_v", g4_am_v, exp_am);
      check("tog_up_ready", g4_up_ready, slot_v_i && !exp_am);
      check("tog_am_sent", g4_am_sent, prev_am_slot);
      prev_am_slot = exp_am && slot_v_i;
      if (slot_v_i) k++;
      tick();
    end
    slot_v_i = 1'b1;

    // BIP on AM_GAP=2: data 66'h1 then 66'h2 gives 0x18 on lane 0
    restart();
    settle();
    check("bip_first_am_v", g2_am_v, 1);
    check("bip_first_bip3", g2_bip3, 0);
    check("bip_first_bip7", g2_bip7, 32'hFFFF_FFFF);
    lane_data_i = '0;
    tick();
    lane_data_i = '0;
    lane_data_i[BLOCK_W-1:0] = 66'h1;
    tick();
    lane_data_i = '0;
    lane_data_i[BLOCK_W-1:0] = 66'h2;
    tick();
    lane_data_i = '0;
    settle();
    check("bip_am_v", g2_am_v, 1);
    check("bip_bip3", g2_bip3, 32'h0000_0018);
    check("bip_bip7", g2_bip7, 32'hFFFF_FFE7);

    // single-bit sweep, lane chosen by j
    for (int j = 2; j < 66; j++) begin
      lane = j % 4;
      lane_data_i = '0;
      tick();
      v = '0;
      v[lane*BLOCK_W + j] = 1'b1;
      lane_data_i = v;
      tick();
      lane_data_i = '0;
      tick();
      settle();
      check("sweep_am_v", g2_am_v, 1);
      check("sweep_bip3", g2_bip3, 32'h1 << (lane*8 + (j - 2) % 8));
    end

    // en_i dropped with the gap counter at 2, then raised
    restart();
    v = '0;
    v[2] = 1'b1;
    lane_data_i = v;
    tick();
    tick();
    tick();
    settle();
    check("drop_pre_am_v", g4_am_v, 0);
    check("drop_pre_up_ready", g4_up_ready, 1);
    check("drop_pre_bip3", g4_bip3, 32'h0000_0001);
    en_i = 1'b0;
    tick();
    settle();
    check("drop_am_v", g4_am_v, 0);
    check("drop_up_ready", g4_up_ready, 0);
    check("drop_bip3", g4_bip3, 0);
    check("drop_bip7", g4_bip7, 32'hFFFF_FFFF);
    check("drop_am_sent", g4_am_sent, 0);
    lane_data_i = '0;
    en_i = 1'b1;
    tick();
    settle();
    check("reen_am_v", g4_am_v, 1);
    check("reen_bip3", g4_bip3, 0);
    check("reen_up_ready", g4_up_ready, 0);
    for (int s = 1; s < 6; s++) begin
      tick();
      settle();
      check("reen_period_am_v", g4_am_v, s == 5);
    end

    // nreset asserted while an AM slot is being consumed
    settle();
    check("nrst_pre_am_v", g4_am_v, 1);
    nreset = 1'b0;
    tick();
    settle();
    check("nrst_am_v", g4_am_v, 0);
    check("nrst_am_sent", g4_am_sent, 0);
    check("nrst_up_ready", g4_up_ready, 0);
    check("nrst_bip7", g4_bip7, 32'hFFFF_FFFF);
    nreset = 1'b1;
    tick();
    settle();
    check("nrst_reissue_am_v", g4_am_v, 1);
    check("nrst_reissue_g2_am_v", g2_am_v, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
